// File: rtl/seg7_pkg.sv
// seg7_pkg: segment decode constants and nibble-to-gfedcba decoder shared by the scan driver.
package seg7_pkg;
   localparam logic [6:0] SEG_0    = 7'h3F;
   localparam logic [6:0] SEG_1    = 7'h06;
   localparam logic [6:0] SEG_2    = 7'h5B;
   localparam logic [6:0] SEG_3    = 7'h4F;
   localparam logic [6:0] SEG_4    = 7'h66;
   localparam logic [6:0] SEG_5    = 7'h6D;
   localparam logic [6:0] SEG_6    = 7'h7D;
   localparam logic [6:0] SEG_7    = 7'h07;
   localparam logic [6:0] SEG_8    = 7'h7F;
   localparam logic [6:0] SEG_9    = 7'h6F;
   localparam logic [6:0] SEG_A    = 7'h77;
   localparam logic [6:0] SEG_B    = 7'h7C;
   localparam logic [6:0] SEG_C    = 7'h39;
   localparam logic [6:0] SEG_D    = 7'h5E;
   localparam logic [6:0] SEG_E    = 7'h79;
   localparam logic [6:0] SEG_F    = 7'h71;
   localparam logic [6:0] SEG_DASH = 7'h40;
   localparam logic [6:0] SEG_OFF  = 7'h00;

   function automatic logic [6:0] seg7_decode(input logic [3:0] nib, input logic hex_en);
      logic [6:0] s;
      case (nib)
         4'h0: s = SEG_0;
         4'h1: s = SEG_1;
         4'h2: s = SEG_2;
         4'h3: s = SEG_3;
         4'h4: s = SEG_4;
         4'h5: s = SEG_5;
         4'h6: s = SEG_6;
         4'h7: s = SEG_7;
         4'h8: s = SEG_8;
         4'h9: s = SEG_9;
         4'hA: s = SEG_A;
         4'hB: s = SEG_B;
         4'hC: s = SEG_C;
         4'hD: s = SEG_D;
         4'hE: s = SEG_E;
         default: s = SEG_F;
      endcase
      return (!hex_en && nib > 4'd9) ? SEG_DASH : s;
   endfunction
endpackage

// File: rtl/seg7_scan_mux_prescaler.sv
// seg7_prescaler: terminal-count counter 0..DIV-1; tick on the last count, clr forces it back to 0.
module seg7_prescaler #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);
   localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0] TC = W'(DIV - 1);
   logic [W-1:0] count_q, count_d;
   always_comb begin
      tick    = en && !clr && count_q == TC;
      count_d = clr ? '0 : !en ? count_q : tick ? '0 : count_q + 1'b1;
   end
   always_ff @(posedge clk) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end
endmodule

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: N-digit multiplexed 7-segment driver with frame snapshot, leading-zero blanking and blink.
module seg7_scan_mux
   import seg7_pkg::*;
#(
   parameter int N_DIGITS    = 4,
   parameter int CLK_HZ      = 100_000_000,
   parameter int REFRESH_HZ  = 1000,
   parameter int BLINK_HZ    = 2,
   parameter int HEX_EN      = 0,
   parameter int AN_ACT_LOW  = 1,
   parameter int SEG_ACT_LOW = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [4*N_DIGITS-1:0] bcd_num,
   input  logic [N_DIGITS-1:0]   dp,
   input  logic                  blank_lz,
   input  logic [N_DIGITS-1:0]   blink_mask,
   output logic [N_DIGITS-1:0]   an,
   output logic [7:0]            segment,
   output logic                  frame_done
);
   localparam int DIV  = (CLK_HZ / REFRESH_HZ > 1) ? CLK_HZ / REFRESH_HZ : 1;
   localparam int BDIV = (CLK_HZ / (2 * BLINK_HZ) > 1) ? CLK_HZ / (2 * BLINK_HZ) : 1;
   localparam int IW   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam logic [IW-1:0]       LAST    = IW'(N_DIGITS - 1);
   localparam logic [N_DIGITS-1:0] AN_IDLE = {N_DIGITS{AN_ACT_LOW != 0}};
   localparam logic [7:0]          SEG_IDLE = {8{SEG_ACT_LOW != 0}};

   logic                  tick, btick, wrap, dark;
   logic [IW-1:0]         idx_q, idx_d;
   logic [4*N_DIGITS-1:0] snap_q, snap_d;
   logic [N_DIGITS-1:0]   dp_snap_q, dp_snap_d;
   logic                  phase_q, phase_d;
   logic                  fd_q, fd_d;
   logic [N_DIGITS-1:0]   an_q, an_d, an_hi, zero_from;
   logic [7:0]            seg_q, seg_d, seg_hi;
   logic [3:0]            nib;

   seg7_prescaler #(.DIV(DIV)) u_scan (
      .clk(clk), .rst(rst), .en(en), .clr(~en), .tick(tick)
   );
   seg7_prescaler #(.DIV(BDIV)) u_blink (
      .clk(clk), .rst(rst), .en(1'b1), .clr(1'b0), .tick(btick)
   );

   always_comb begin
      wrap      = tick && idx_q == LAST;
      idx_d     = (!en || wrap) ? '0 : tick ? idx_q + 1'b1 : idx_q;
      snap_d    = wrap ? bcd_num : snap_q;
      dp_snap_d = wrap ? dp : dp_snap_q;
      phase_d   = btick ? ~phase_q : phase_q;
      fd_d      = wrap;
      // zero_from[i]: every snapshot digit from i upward is zero
      for (int i = 0; i < N_DIGITS; i++) zero_from[i] = (snap_q >> (4 * i)) == '0;
      nib    = snap_q[4*int'(idx_q) +: 4];
      dark   = !en || (phase_q && blink_mask[idx_q]) || (blank_lz && idx_q != '0 && zero_from[idx_q]);
      an_hi  = dark ? '0 : N_DIGITS'(1) << idx_q;
      seg_hi = dark ? '0 : {dp_snap_q[idx_q], seg7_decode(nib, HEX_EN != 0)};
      an_d   = (AN_ACT_LOW != 0) ? ~an_hi : an_hi;
      seg_d  = (SEG_ACT_LOW != 0) ? ~seg_hi : seg_hi;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q     <= '0;
         snap_q    <= '0;
         dp_snap_q <= '0;
         phase_q   <= 1'b0;
         fd_q      <= 1'b0;
         an_q      <= AN_IDLE;
         seg_q     <= SEG_IDLE;
      end else begin
         idx_q     <= idx_d;
         snap_q    <= snap_d;
         dp_snap_q <= dp_snap_d;
         phase_q   <= phase_d;
         fd_q      <= fd_d;
         an_q      <= an_d;
         seg_q     <= seg_d;
      end
   end

   assign an         = an_q;
   assign segment    = seg_q;
   assign frame_done = fd_q;
endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb_seg7_scan_mux: scoreboard bench for two seg7_scan_mux instances (dash and hex modes) plus directed checks.
module tb_seg7_scan_mux;
   logic        clk = 1'b0;
   logic        rst, en, blank_lz;
   logic [15:0] bcd_num;
   logic [3:0]  dp, blink_mask;
   logic [3:0]  an, an_h;
   logic [7:0]  seg, seg_h;
   logic        fd, fd_h;
   int          n_tests = 0;
   int          n_fail  = 0;

   always #5 clk = ~clk;

   seg7_scan_mux #(.N_DIGITS(4), .CLK_HZ(1000), .REFRESH_HZ(250), .BLINK_HZ(25),
                   .HEX_EN(0), .AN_ACT_LOW(1), .SEG_ACT_LOW(1)) dut (
      .clk(clk), .rst(rst), .en(en), .bcd_num(bcd_num), .dp(dp), .blank_lz(blank_lz),
      .blink_mask(blink_mask), .an(an), .segment(seg), .frame_done(fd)
   );
   seg7_scan_mux #(.N_DIGITS(4), .CLK_HZ(1000), .REFRESH_HZ(250), .BLINK_HZ(25),
                   .HEX_EN(1), .AN_ACT_LOW(1), .SEG_ACT_LOW(1)) dut_hex (
      .clk(clk), .rst(rst), .en(en), .bcd_num(bcd_num), .dp(dp), .blank_lz(blank_lz),
      .blink_mask(blink_mask), .an(an_h), .segment(seg_h), .frame_done(fd_h)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [3:0] an;
      logic [7:0] seg;
      logic [7:0] seg_h;
      logic       fd;
   } exp_t;
   exp_t sb[$];

   localparam logic [6:0] DEC [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                       7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   function automatic logic [7:0] mseg(input logic [3:0] n, input logic d, input bit hex);
      logic [6:0] g;
      g = (hex || n < 4'd10) ? DEC[n] : 7'h40;
      return ~{d, g};
   endfunction

   int          m_cnt, m_idx, m_bcnt;
   bit          m_ph, live = 0;
   logic [15:0] m_snap;
   logic [3:0]  m_dp;

   // reference model: expected registered outputs for each edge, checked on the following falling edge
   always @(posedge clk) begin
      exp_t e;
      bit   dark, allz;
      logic [3:0] n;
      if (rst) begin
         e = '{4'hF, 8'hFF, 8'hFF, 1'b0};
         m_cnt = 0; m_idx = 0; m_bcnt = 0; m_ph = 0; m_snap = '0; m_dp = '0;
         live = 1;
      end else if (live) begin
         allz = 1;
         for (int j = m_idx; j < 4; j++) if (m_snap[4*j +: 4] != 4'h0) allz = 0;
         dark = !en || (m_ph && blink_mask[m_idx]) || (blank_lz && m_idx > 0 && allz);
         n = m_snap[4*m_idx +: 4];
         e.an    = dark ? 4'hF : ~(4'b0001 << m_idx);
         e.seg   = dark ? 8'hFF : mseg(n, m_dp[m_idx], 0);
         e.seg_h = dark ? 8'hFF : mseg(n, m_dp[m_idx], 1);
         e.fd    = en && m_cnt == 3 && m_idx == 3;
         if (!en) begin
            m_cnt = 0; m_idx = 0;
         end else if (m_cnt == 3) begin
            m_cnt = 0;
            if (m_idx == 3) begin
               m_idx = 0; m_snap = bcd_num; m_dp = dp;
            end else m_idx++;
         end else m_cnt++;
         if (m_bcnt == 19) begin
            m_bcnt = 0; m_ph = !m_ph;
         end else m_bcnt++;
      end
      if (live) sb.push_back(e);
   end

   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("sb_an", an, e.an);
         chk("sb_an_hex", an_h, e.an);
         chk("sb_seg", seg, e.seg);
         chk("sb_seg_hex", seg_h, e.seg_h);
         chk("sb_fd", fd, e.fd);
         chk("sb_fd_hex", fd_h, e.fd);
      end
   end

   task automatic wait_an(input logic [3:0] t, input string tag);
      int k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (an !== t && k < 64);
      if (an !== t) chk({tag, "_an_timeout"}, an, t);
   endtask

   task automatic wait_fd(input string tag);
      int k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (fd !== 1'b1 && k < 64);
      if (fd !== 1'b1) chk({tag, "_fd_timeout"}, fd, 1);
   endtask

   task automatic wait_lit(input string tag);
      int k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (an === 4'hF && k < 12);
      chk(tag, an, 4'b1110);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      int cnt;
      rst = 1; en = 1; bcd_num = 16'h0123; dp = 4'h0; blank_lz = 0; blink_mask = 4'h0;
      repeat (3) @(negedge clk);
      chk("rst_an", an, 4'hF);
      chk("rst_seg", seg, 8'hFF);
      chk("rst_fd", fd, 0);
      rst = 0;
      // basic scan of 0123
      wait_fd("t1");
      wait_an(4'b1110, "t1_d0"); chk("t1_d0_seg", seg, 8'hB0);
      wait_an(4'b1101, "t1_d1"); chk("t1_d1_seg", seg, 8'hA4);
      wait_an(4'b1011, "t1_d2"); chk("t1_d2_seg", seg, 8'hF9);
      wait_an(4'b0111, "t1_d3"); chk("t1_d3_seg", seg, 8'hC0);
      // leading-zero blanking
      blank_lz = 1;
      wait_an(4'b1101, "t2_d1"); chk("t2_d1_seg", seg, 8'hA4);
      wait_an(4'b1011, "t2_d2"); chk("t2_d2_seg", seg, 8'hF9);
      wait_an(4'b1110, "t2_d0"); chk("t2_d0_seg", seg, 8'hB0);
      cnt = 0;
      repeat (16) begin
         @(negedge clk);
         if (an == 4'b0111 || (an == 4'hF && seg != 8'hFF)) cnt++;
      end
      chk("t2_d3_dark", cnt, 0);
      bcd_num = 16'h0000;
      wait_fd("t2z");
      cnt = 0;
      repeat (16) begin
         @(negedge clk);
         if (an != 4'hF && an != 4'b1110) cnt++;
      end
      chk("t2_only_d0", cnt, 0);
      wait_an(4'b1110, "t2z_d0"); chk("t2z_d0_seg", seg, 8'hC0);
      // mid-frame update is deferred to the next frame
      blank_lz = 0; bcd_num = 16'h0123;
      wait_fd("t3a");
      wait_an(4'b1101, "t3_d1");
      bcd_num = 16'h4567;
      wait_an(4'b1011, "t3_d2_old"); chk("t3_d2_old_seg", seg, 8'hF9);
      wait_an(4'b0111, "t3_d3_old"); chk("t3_d3_old_seg", seg, 8'hC0);
      wait_fd("t3b");
      wait_an(4'b1110, "t3_d0_new"); chk("t3_d0_new_seg", seg, 8'hF8);
      wait_an(4'b1101, "t3_d1_new"); chk("t3_d1_new_seg", seg, 8'h82);
      // blink on digit 0, covered by the scoreboard
      blink_mask = 4'b0001;
      repeat (120) @(negedge clk);
      blink_mask = 4'b0000;
      // dash vs hex and decimal point
      bcd_num = 16'h00AF; dp = 4'b0001;
      wait_fd("t5");
      wait_an(4'b1110, "t5_d0");
      chk("t5_d0_dash", seg, 8'h3F);
      chk("t5_d0_hex", seg_h, 8'h0E);
      wait_an(4'b1101, "t5_d1");
      chk("t5_d1_dash", seg, 8'hBF);
      chk("t5_d1_hex", seg_h, 8'h88);
      wait_an(4'b1011, "t5_d2"); chk("t5_d2_seg", seg, 8'hC0);
      // reset mid-scan and enable gating
      dp = 4'h0;
      wait_an(4'b1011, "t6_pre");
      rst = 1;
      @(negedge clk);
      chk("t6_rst_an", an, 4'hF);
      chk("t6_rst_seg", seg, 8'hFF);
      rst = 0;
      wait_lit("t6_first_digit");
      repeat (5) @(negedge clk);
      en = 0;
      repeat (2) @(negedge clk);
      chk("t6_en0_an", an, 4'hF);
      chk("t6_en0_seg", seg, 8'hFF);
      repeat (10) @(negedge clk);
      en = 1;
      wait_lit("t6_en_restart");
      repeat (40) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
